// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU arbiter.
//   - default DATA_W / OP_W / CNT_W widths
//   - FSM state type and state encodings (IDLE / EXEC / RESP)
//   - requester index type (two requesters)
package alu_arb_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OP_W_DEF   = 4;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Index of a requester: 0 or 1.
    typedef logic req_idx_t;

endpackage

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: combinational 2-way round-robin picker.
// Ports:
//   req_valid  in  2  request bits, bit i = requester i
//   last_grant in  1  requester granted most recently
//   grant      out 2  one-hot winner (0 when no request)
//   any        out 1  at least one request present
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  req_idx_t   last_grant,
    output logic [1:0] grant,
    output logic       any
);

    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: the requester not served last time wins.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign any = |req_valid;

endmodule

// File: rtl/alu_arb.sv
// alu_arb: two-requester round-robin arbiter/sequencer for an external
// combinational ALU. One transaction in flight: IDLE -> EXEC -> RESP.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (2 bits)
//   req_a/req_b/req_op    packed payloads, requester i in slice i
//   rsp_valid/rsp_ready   per-requester response handshake (2 bits)
//   rsp_data              result shared by both requesters
//   alu_ain/bin/ctrl      registered operands to the ALU
//   alu_out               ALU result
//   busy                  FSM not idle
//   stats_clr             synchronous clear of grant counters
//   grant_cnt0/1          saturating per-requester grant counts
// Build option: ALU_ARB_STATS_EN enables the grant counters; when undefined
// the counters read 0 and stats_clr is ignored.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*OP_W-1:0]   req_op,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [DATA_W-1:0]   alu_ain,
    output logic [DATA_W-1:0]   alu_bin,
    output logic [OP_W-1:0]     alu_ctrl,
    input  logic [DATA_W-1:0]   alu_out,
    output logic                busy,
    input  logic                stats_clr,
    output logic [CNT_W-1:0]    grant_cnt0,
    output logic [CNT_W-1:0]    grant_cnt1
);

    state_t              state;
    req_idx_t            owner;
    req_idx_t            last_grant;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [OP_W-1:0]     opc;
    logic [DATA_W-1:0]   result;

    logic [1:0]          grant;
    logic                any;
    req_idx_t            winner;
    logic                accept;

    alu_arb_rr u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any)
    );

    assign winner = grant[1];
    assign accept = (state == ST_IDLE) && any;

    // Gated by rst so every output reads 0 while reset is held.
    assign req_ready = ((state == ST_IDLE) && !rst) ? grant : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            opa        <= '0;
            opb        <= '0;
            opc        <= '0;
            result     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        opa        <= winner ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                        opb        <= winner ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                        opc        <= winner ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
                        owner      <= winner;
                        last_grant <= winner;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result <= alu_out;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[owner]) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state == ST_RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    assign rsp_data = result;
    assign alu_ain  = opa;
    assign alu_bin  = opb;
    assign alu_ctrl = opc;
    assign busy     = (state != ST_IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (stats_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (accept) begin
            if (!winner && (cnt0 != '1)) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (winner && (cnt1 != '1)) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

    assign grant_cnt0 = cnt0;
    assign grant_cnt1 = cnt1;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign grant_cnt0       = '0;
    assign grant_cnt1       = '0;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed self-checking bench for alu_arb with a bench-side
// combinational ALU model on the alu_* nets. Expected results are
// hand-computed constants.
module tb_alu_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_data;
    logic [7:0]  alu_ain;
    logic [7:0]  alu_bin;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_out;
    logic        busy;
    logic        stats_clr;
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;

    int checks = 0;
    int errors = 0;

    alu_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_ain    (alu_ain),
        .alu_bin    (alu_bin),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .busy       (busy),
        .stats_clr  (stats_clr),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass A.
    always_comb begin
        case (alu_ctrl)
            4'h0:    alu_out = alu_ain + alu_bin;
            4'h1:    alu_out = alu_ain - alu_bin;
            4'h2:    alu_out = alu_ain & alu_bin;
            4'h3:    alu_out = alu_ain | alu_bin;
            4'h4:    alu_out = alu_ain ^ alu_bin;
            default: alu_out = alu_ain;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op);
        if (i == 0) begin
            req_a[7:0]  = a;
            req_b[7:0]  = b;
            req_op[3:0] = op;
        end else begin
            req_a[15:8] = a;
            req_b[15:8] = b;
            req_op[7:4] = op;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
        chk({tag, "_alu_ain"}, {24'd0, alu_ain}, 32'd0);
        chk({tag, "_alu_bin"}, {24'd0, alu_bin}, 32'd0);
        chk({tag, "_alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
        chk({tag, "_cnt0"}, {16'd0, grant_cnt0}, 32'd0);
        chk({tag, "_cnt1"}, {16'd0, grant_cnt1}, 32'd0);
    endtask

    logic [7:0] exp_data [2];
    int         w;
    int         exp_cnt0;
    int         exp_cnt1;

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 2'b00;
        stats_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_outputs_zero("reset");

        // Single request from requester 0: 0F + 01 = 10.
        set_req(0, 8'h0F, 8'h01, 4'h0);
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        #1;
        chk("single_req_ready", {30'd0, req_ready}, 32'h1);
        step();
        req_valid = 2'b00;
        chk("single_exec_busy", {31'd0, busy}, 32'h1);
        chk("single_exec_rsp_valid", {30'd0, rsp_valid}, 32'h0);
        chk("single_exec_req_ready", {30'd0, req_ready}, 32'h0);
        chk("single_exec_ain", {24'd0, alu_ain}, 32'h0F);
        chk("single_exec_bin", {24'd0, alu_bin}, 32'h01);
        chk("single_exec_ctrl", {28'd0, alu_ctrl}, 32'h0);
        step();
        chk("single_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("single_rsp_data", {24'd0, rsp_data}, 32'h10);
        step();
        chk("single_done_busy", {31'd0, busy}, 32'h0);
        chk("single_done_rsp_valid", {30'd0, rsp_valid}, 32'h0);

        // Asynchronous reset mid-cycle while holding a response: 33 | 44 = 77.
        set_req(0, 8'h33, 8'h44, 4'h3);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        chk("pre_rst_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("pre_rst_rsp_data", {24'd0, rsp_data}, 32'h77);
        #3;
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_rst");
        step();
        rst = 1'b0;
        step();

        // Reset pulse during EXEC of a requester-1 transaction: 05 - 03.
        set_req(1, 8'h05, 8'h03, 4'h1);
        req_valid = 2'b10;
        #1;
        chk("exec_rst_req_ready", {30'd0, req_ready}, 32'h2);
        step();
        req_valid = 2'b00;
        chk("exec_rst_busy", {31'd0, busy}, 32'h1);
        chk("exec_rst_cnt1_pre", {16'd0, grant_cnt1},
`ifdef ALU_ARB_STATS_EN
            32'h1
`else
            32'h0
`endif
        );
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("exec_rst_busy_after", {31'd0, busy}, 32'h0);
        chk("exec_rst_cnt1_after", {16'd0, grant_cnt1}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("exec_rst_no_rsp", {30'd0, rsp_valid}, 32'h0);
            chk("exec_rst_idle", {31'd0, busy}, 32'h0);
        end

        // Contention: 12 + 34 = 46 for req0, F0 ^ 0F = FF for req1.
        set_req(0, 8'h12, 8'h34, 4'h0);
        set_req(1, 8'hF0, 8'h0F, 4'h4);
        exp_data[0] = 8'h46;
        exp_data[1] = 8'hFF;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            w = n % 2;
            chk("cont_req_ready", {30'd0, req_ready}, 32'(1 << w));
            step();
            chk("cont_exec_req_ready", {30'd0, req_ready}, 32'h0);
            chk("cont_exec_ain", {24'd0, alu_ain}, (w == 0) ? 32'h12 : 32'hF0);
            step();
            chk("cont_rsp_valid", {30'd0, rsp_valid}, 32'(1 << w));
            chk("cont_rsp_data", {24'd0, rsp_data}, {24'd0, exp_data[w]});
            step();
        end

        // Backpressure: 80 - 01 = 7F; non-owner rsp_ready must be ignored.
        set_req(0, 8'h80, 8'h01, 4'h1);
        req_valid = 2'b01;
        rsp_ready = 2'b10;
        #1;
        chk("bp_req_ready", {30'd0, req_ready}, 32'h1);
        step();
        req_valid = 2'b11;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'h1);
            chk("bp_rsp_data", {24'd0, rsp_data}, 32'h7F);
            chk("bp_req_ready_low", {30'd0, req_ready}, 32'h0);
            step();
        end
        rsp_ready = 2'b01;
        #1;
        chk("bp_release_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        step();
        chk("bp_done_busy", {31'd0, busy}, 32'h0);
        chk("bp_next_winner", {30'd0, req_ready}, 32'h2);
        req_valid = 2'b00;
        step();

        // Grant counters: 3 grants to requester 0, 2 to requester 1 since reset.
`ifdef ALU_ARB_STATS_EN
        exp_cnt0 = 3;
        exp_cnt1 = 2;
`else
        exp_cnt0 = 0;
        exp_cnt1 = 0;
`endif
        chk("stats_cnt0", {16'd0, grant_cnt0}, 32'(exp_cnt0));
        chk("stats_cnt1", {16'd0, grant_cnt1}, 32'(exp_cnt1));
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("stats_clr_cnt0", {16'd0, grant_cnt0}, 32'h0);
        chk("stats_clr_cnt1", {16'd0, grant_cnt1}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
